// File: rtl/turn_timer_pkg.sv
// Shared types and constants for the per-turn countdown timer.
package turn_timer_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

  localparam int unsigned WARN_SECS = 5;
  localparam int unsigned SECS_W    = 7;

endpackage

// File: rtl/tick_prescaler.sv
// Down-counter producing a one-cycle wrap strobe every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic reload,
  output logic tick
);

  localparam int unsigned      CntW   = $clog2(TICK_DIV);
  localparam logic [CntW-1:0]  CntTop = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = en && (cnt_q == '0);

  always_ff @(posedge clock) begin
    if (!reset_n || reload) begin
      cnt_q <= CntTop;
    end else if (en) begin
      cnt_q <= (cnt_q == '0) ? CntTop : cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/turn_timer.sv
// Per-turn countdown timer with player rotation and BCD seconds display.
// Optional low-time warning output enabled by defining TURN_TIMER_WARN_EN.
module turn_timer
  import turn_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned TURN_SECS   = 15,
  parameter int unsigned NUM_PLAYERS = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           turn_done,
  output logic [$clog2(NUM_PLAYERS)-1:0] player,
  output logic [SECS_W-1:0]              secs_left,
  output logic [3:0]                     bcd_tens,
  output logic [3:0]                     bcd_ones,
  output logic                           tick,
  output logic                           timeout,
  output logic                           running,
  output logic                           warn
);

  localparam int unsigned             PlayerW   = $clog2(NUM_PLAYERS);
  localparam logic [SECS_W-1:0]       TurnSecs  = SECS_W'(TURN_SECS);
  localparam logic [PlayerW-1:0]      LastPlayer = PlayerW'(NUM_PLAYERS - 1);

  state_e               state_q;
  logic [SECS_W-1:0]    secs_q;
  logic [PlayerW-1:0]   player_q;
  logic [PlayerW-1:0]   player_next;
  logic                 tick_q;
  logic                 timeout_q;
  logic                 active;
  logic                 move_ack;
  logic                 presc_en;
  logic                 presc_reload;
  logic                 presc_tick;

  assign active      = (state_q == StRun) || (state_q == StPaused);
  assign move_ack    = active && turn_done;
  assign player_next = (player_q == LastPlayer) ? '0 : player_q + PlayerW'(1);

  // start, pause and a move all suppress the prescaler so none of them can race a tick.
  assign presc_en     = (state_q == StRun) && !pause && !turn_done && !start;
  assign presc_reload = start || move_ack || (state_q == StExpired);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (presc_en),
    .reload  (presc_reload),
    .tick    (presc_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      secs_q    <= TurnSecs;
      player_q  <= '0;
      tick_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      tick_q    <= 1'b0;
      timeout_q <= 1'b0;
      if (start) begin
        state_q  <= StRun;
        secs_q   <= TurnSecs;
        player_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StIdle;
          end
          StRun, StPaused: begin
            state_q <= pause ? StPaused : StRun;
            if (turn_done) begin
              player_q <= player_next;
              secs_q   <= TurnSecs;
            end else if (presc_tick) begin
              tick_q <= 1'b1;
              if (secs_q <= SECS_W'(1)) begin
                secs_q    <= '0;
                timeout_q <= 1'b1;
                state_q   <= StExpired;
              end else begin
                secs_q <= secs_q - SECS_W'(1);
              end
            end
          end
          StExpired: begin
            player_q <= player_next;
            secs_q   <= TurnSecs;
            state_q  <= pause ? StPaused : StRun;
          end
        endcase
      end
    end
  end

`ifdef TURN_TIMER_WARN_EN
  logic warn_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= active && (secs_q != '0) && (secs_q <= SECS_W'(WARN_SECS));
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  assign player    = player_q;
  assign secs_left = secs_q;
  assign bcd_tens  = 4'(secs_q / SECS_W'(10));
  assign bcd_ones  = 4'(secs_q % SECS_W'(10));
  assign tick      = tick_q;
  assign timeout   = timeout_q;
  assign running   = (state_q == StRun);

endmodule

// File: tb/tb_turn_timer.sv
// Directed bench: a small timer (4/3/3) for control flow and a 15 s timer for BCD and warn.
module tb_turn_timer;

`ifdef TURN_TIMER_WARN_EN
  localparam bit WarnOn = 1'b1;
`else
  localparam bit WarnOn = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, start, pause, turn_done, start2, pause2, turn_done2;
  logic [1:0] player;
  logic [6:0] secs_left;
  logic [3:0] bcd_tens, bcd_ones;
  logic       tick, timeout, running, warn;
  logic [0:0] player2;
  logic [6:0] secs_left2;
  logic [3:0] bcd_tens2, bcd_ones2;
  logic       tick2, timeout2, running2, warn2;

  int n_checks = 0;
  int n_pass   = 0;
  int n;
  int bad;

  turn_timer #(
    .TICK_DIV    (4),
    .TURN_SECS   (3),
    .NUM_PLAYERS (3)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .pause     (pause),
    .turn_done (turn_done),
    .player    (player),
    .secs_left (secs_left),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .tick      (tick),
    .timeout   (timeout),
    .running   (running),
    .warn      (warn)
  );

  turn_timer #(
    .TICK_DIV    (2),
    .TURN_SECS   (15),
    .NUM_PLAYERS (2)
  ) dut2 (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start2),
    .pause     (pause2),
    .turn_done (turn_done2),
    .player    (player2),
    .secs_left (secs_left2),
    .bcd_tens  (bcd_tens2),
    .bcd_ones  (bcd_ones2),
    .tick      (tick2),
    .timeout   (timeout2),
    .running   (running2),
    .warn      (warn2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Cycles until the next tick of the small timer; -1 if none within budget.
  task automatic wait_tick(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (tick) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Model of the 15 s timer, s = cycles since the start edge.
  function automatic int m_secs(input int s);
    return (s > 30) ? 15 : 15 - s / 2;
  endfunction

  function automatic int m_warn(input int s);
    if (s == 0 || (s - 1) == 30) return 0;
    return (WarnOn && m_secs(s - 1) >= 1 && m_secs(s - 1) <= 5) ? 1 : 0;
  endfunction

  initial begin
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; turn_done = 1'b0;
    start2 = 1'b0; pause2 = 1'b0; turn_done2 = 1'b0;
    step(); step();
    check("rst_running", running, 0);
    check("rst_secs", secs_left, 3);
    check("rst_player", player, 0);
    check("rst_tick", tick, 0);
    check("rst_timeout", timeout, 0);
    check("rst_warn", warn, 0);
    check("rst_secs2", secs_left2, 15);

    // Idle without start
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick || running || secs_left != 7'd3) bad++;
    end
    check("idle_quiet", bad, 0);

    // Natural expiry, three times around
    start = 1'b1; step(); start = 1'b0;
    check("start_running", running, 1);
    check("start_secs", secs_left, 3);
    check("start_player", player, 0);
    for (int e = 1; e <= 3; e++) begin
      wait_tick(n); check("exp_tick1_gap", n, 4); check("exp_secs2", secs_left, 2);
      wait_tick(n); check("exp_tick2_gap", n, 4); check("exp_secs1", secs_left, 1);
      check("exp_no_early_timeout", timeout, 0);
      wait_tick(n); check("exp_tick3_gap", n, 4); check("exp_secs0", secs_left, 0);
      check("exp_timeout", timeout, 1);
      check("exp_state_expired", running, 0);
      step();
      check("exp_player", player, e % 3);
      check("exp_reload", secs_left, 3);
      check("exp_running", running, 1);
      check("exp_timeout_pulse", timeout, 0);
    end

    // Move in the cycle of the final tick
    wait_tick(n); wait_tick(n);
    check("move_pre_secs", secs_left, 1);
    step(); step(); step();
    turn_done = 1'b1; step(); turn_done = 1'b0;
    check("move_no_tick", tick, 0);
    check("move_no_timeout", timeout, 0);
    check("move_player", player, 1);
    check("move_secs", secs_left, 3);
    check("move_running", running, 1);
    wait_tick(n); check("move_tick_gap", n, 4); check("move_secs2", secs_left, 2);

    // Pause holds prescaler and seconds
    step();
    pause = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick || running || secs_left != 7'd2) bad++;
    end
    check("pause_frozen", bad, 0);
    pause = 1'b0; step();
    check("pause_resume_running", running, 1);
    wait_tick(n); check("pause_resume_gap", n, 3); check("pause_secs", secs_left, 1);

    // Restart from player 2 with one second left, then mid-run reset
    turn_done = 1'b1; step(); turn_done = 1'b0;
    wait_tick(n); wait_tick(n);
    check("rs_pre_player", player, 2);
    check("rs_pre_secs", secs_left, 1);
    start = 1'b1; step(); start = 1'b0;
    check("rs_player", player, 0);
    check("rs_secs", secs_left, 3);
    check("rs_running", running, 1);
    wait_tick(n); check("rs_tick_gap", n, 4);
    turn_done = 1'b1; step(); turn_done = 1'b0;
    wait_tick(n);
    check("mr_pre_player", player, 1);
    reset_n = 1'b0; step();
    check("mr_running", running, 0);
    check("mr_secs", secs_left, 3);
    check("mr_player", player, 0);
    check("mr_tick", tick, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("mr_stays_idle", running, 0);

    // BCD split and warning on the 15 s timer
    start2 = 1'b1; step(); start2 = 1'b0;
    check("bcd15_tens", bcd_tens2, 1);
    check("bcd15_ones", bcd_ones2, 5);
    for (int s = 0; s <= 31; s++) begin
      if (s > 0) step();
      check($sformatf("t2_secs_s%0d", s), secs_left2, m_secs(s));
      check($sformatf("t2_tens_s%0d", s), bcd_tens2, m_secs(s) / 10);
      check($sformatf("t2_ones_s%0d", s), bcd_ones2, m_secs(s) % 10);
      check($sformatf("t2_warn_s%0d", s), warn2, m_warn(s));
      if (s == 10) begin
        check("bcd10_tens", bcd_tens2, 1);
        check("bcd10_ones", bcd_ones2, 0);
      end
      if (s == 12) begin
        check("bcd9_tens", bcd_tens2, 0);
        check("bcd9_ones", bcd_ones2, 9);
      end
      if (s == 30) begin
        check("t2_timeout", timeout2, 1);
        check("t2_expired", running2, 0);
      end
      if (s == 31) check("t2_player", player2, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
